// File: rtl/mem_line_sequencer.sv
// mem_line_sequencer
//   Splits a wide cache-line request into a short sequence of memory-controller
//   app-interface commands and write-data beats, then collects read beats back
//   into a full line and returns a single response.
//
//   Line layout: beat j of a line is data[j*BEAT_W +: BEAT_W] with byte enables
//   strb[j*BEAT_W/8 +: BEAT_W/8]. Command k covers beats
//   k*BEATS_PER_CMD .. k*BEATS_PER_CMD+BEATS_PER_CMD-1 and targets app address
//   {addr, ADDR_LSB zeros} + k*CMD_ADDR_INC, wrapping at the port width.
//
//   Optional build macro:
//     MEM_SEQ_MASK_SKIP_EN - write commands whose byte enables are all zero are
//                            not issued at all (no command, no data beats).
//                            Undefined: every command and beat is issued and
//                            fully masked beats go out with mask all ones.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_* / o_req_ready line request (we, line addr, byte strobes, line data)
//   o_rsp_* / i_rsp_ready line response (write ack flag, read line data)
//   o_app_en/cmd/addr     app command channel, i_app_rdy accepts
//   o_app_wdf_*           app write-data channel, i_app_wdf_rdy accepts
//   i_app_rd_data*        app read-data return
//   o_err                 sticky: read data arrived while no read was pending
module mem_line_sequencer #(
  parameter int ADDR_W        = 23,
  parameter int ADDR_LSB      = 4,
  parameter int BEAT_W        = 64,
  parameter int BEATS_PER_CMD = 2,
  parameter int CMDS_PER_LINE = 2,
  parameter int CMD_ADDR_INC  = 8,
  localparam int LINE_W       = BEAT_W * BEATS_PER_CMD * CMDS_PER_LINE,
  localparam int STRB_W       = LINE_W / 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_we,
  input  logic [ADDR_W-1:0]          i_req_addr,
  input  logic [STRB_W-1:0]          i_req_strb,
  input  logic [LINE_W-1:0]          i_req_data,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic                       o_rsp_we,
  output logic [LINE_W-1:0]          o_rsp_data,
  output logic                       o_app_en,
  output logic [2:0]                 o_app_cmd,
  output logic [ADDR_W+ADDR_LSB-1:0] o_app_addr,
  input  logic                       i_app_rdy,
  output logic [BEAT_W-1:0]          o_app_wdf_data,
  output logic [BEAT_W/8-1:0]        o_app_wdf_mask,
  output logic                       o_app_wdf_wren,
  output logic                       o_app_wdf_end,
  input  logic                       i_app_wdf_rdy,
  input  logic [BEAT_W-1:0]          i_app_rd_data,
  input  logic                       i_app_rd_data_valid,
  input  logic                       i_app_rd_data_end,
  output logic                       o_err
);

  localparam int NBEATS = BEATS_PER_CMD * CMDS_PER_LINE;
  localparam int BEAT_B = BEAT_W / 8;
  localparam int CMD_B  = BEATS_PER_CMD * BEAT_B;
  localparam int APP_AW = ADDR_W + ADDR_LSB;
  localparam int CW     = $clog2(CMDS_PER_LINE + 1);
  localparam int WBW    = $clog2(BEATS_PER_CMD + 1);
  localparam int RCW    = $clog2(NBEATS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_CMD  = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t state, state_nxt;

  // request capture
  logic [ADDR_W-1:0] addr_q;
  logic [STRB_W-1:0] strb_q;
  logic [LINE_W-1:0] wdata_q;

  // response
  logic [LINE_W-1:0] rsp_data_q;
  logic              rsp_we_q;
  logic              err_q;

  // sequencing counters
  logic [CW-1:0]  cmd_idx;    // current command within the line
  logic [WBW-1:0] wbeat;      // write beat within the current command
  logic           cmd_acc;    // current write command already accepted
  logic           beats_acc;  // all beats of current write command accepted
  logic [RCW-1:0] rd_cnt;     // read beats collected so far

  logic           req_fire;
  logic           cmd_fire;
  logic           beat_fire;
  logic           last_beat;
  logic           last_cmd;
  logic           wr_none;
  logic           wr_step;
  logic [CW-1:0]  wr_first_idx;
  logic [CW-1:0]  wr_next_idx;
  logic           rd_take;
  logic [RCW-1:0] rd_cnt_nxt;
  logic           rd_full_nxt;
  logic [RCW-1:0] wr_beat_idx;

  // The end-of-burst marker is redundant with the beat count kept here.
  logic unused_rd_end;
  assign unused_rd_end = i_app_rd_data_end;

`ifdef MEM_SEQ_MASK_SKIP_EN
  // First command at or after 'from' that has at least one enabled byte;
  // CMDS_PER_LINE when none remain.
  function automatic logic [CW-1:0] next_cmd(input logic [CW-1:0] from,
                                             input logic [STRB_W-1:0] strb);
    logic [CW-1:0] res;
    res = CW'(CMDS_PER_LINE);
    for (int k = CMDS_PER_LINE - 1; k >= 0; k--) begin
      if ((CW'(k) >= from) && (strb[k*CMD_B +: CMD_B] != '0)) res = CW'(k);
    end
    return res;
  endfunction

  assign wr_first_idx = next_cmd('0, i_req_strb);
  assign wr_next_idx  = next_cmd(cmd_idx + CW'(1), strb_q);
`else
  assign wr_first_idx = '0;
  assign wr_next_idx  = cmd_idx + CW'(1);
`endif

  assign req_fire    = i_req_valid && o_req_ready;
  assign cmd_fire    = o_app_en && i_app_rdy;
  assign beat_fire   = o_app_wdf_wren && i_app_wdf_rdy;
  assign last_beat   = (wbeat == WBW'(BEATS_PER_CMD - 1));
  assign last_cmd    = (cmd_idx == CW'(CMDS_PER_LINE - 1));
  // Only reachable with mask skipping: no command left to issue.
  assign wr_none     = (cmd_idx == CW'(CMDS_PER_LINE));
  // Command and its data beats finish independently, in either order or together.
  assign wr_step     = (state == WR) && !wr_none &&
                       (cmd_acc || cmd_fire) &&
                       (beats_acc || (beat_fire && last_beat));
  assign rd_take     = i_app_rd_data_valid &&
                       ((state == RD_CMD) || (state == RD_DATA)) &&
                       (rd_cnt != RCW'(NBEATS));
  assign rd_cnt_nxt  = rd_cnt + RCW'(rd_take);
  assign rd_full_nxt = (rd_cnt_nxt == RCW'(NBEATS));
  assign wr_beat_idx = RCW'(cmd_idx) * RCW'(BEATS_PER_CMD) + RCW'(wbeat);

  assign o_app_addr  = {addr_q, {ADDR_LSB{1'b0}}} +
                       APP_AW'(cmd_idx) * APP_AW'(CMD_ADDR_INC);
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_we    = rsp_we_q;
  assign o_err       = err_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) state_nxt = i_req_we ? WR : RD_CMD;
      end
      WR: begin
        if (wr_none || (wr_step && (wr_next_idx == CW'(CMDS_PER_LINE))))
          state_nxt = RESP;
      end
      RD_CMD: begin
        // A beat arriving alongside the last command still counts here.
        if (cmd_fire && last_cmd) state_nxt = rd_full_nxt ? RESP : RD_DATA;
      end
      RD_DATA: begin
        if (rd_full_nxt) state_nxt = RESP;
      end
      RESP: begin
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready    = (state == IDLE) && !i_rst;
    o_rsp_valid    = (state == RESP);
    o_app_en       = ((state == WR) && !wr_none && !cmd_acc) || (state == RD_CMD);
    o_app_cmd      = (state == RD_CMD) ? 3'b001 : 3'b000;
    o_app_wdf_wren = (state == WR) && !wr_none && !beats_acc;
    o_app_wdf_end  = o_app_wdf_wren && last_beat;
    o_app_wdf_data = '0;
    o_app_wdf_mask = '0;
    for (int j = 0; j < NBEATS; j++) begin
      if (wr_beat_idx == RCW'(j)) begin
        o_app_wdf_data = wdata_q[j*BEAT_W +: BEAT_W];
        o_app_wdf_mask = ~strb_q[j*BEAT_B +: BEAT_B];
      end
    end
  end

  // Write line and strobes: plain data, loaded on acceptance only
  always_ff @(posedge i_clk) begin
    if (req_fire) begin
      strb_q  <= i_req_strb;
      wdata_q <= i_req_data;
    end
  end

  // Sequencing counters, response registers and error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      cmd_idx    <= '0;
      wbeat      <= '0;
      cmd_acc    <= 1'b0;
      beats_acc  <= 1'b0;
      rd_cnt     <= '0;
      rsp_we_q   <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (i_app_rd_data_valid && (state != RD_CMD) && (state != RD_DATA))
        err_q <= 1'b1;

      if (req_fire) begin
        addr_q    <= i_req_addr;
        rsp_we_q  <= i_req_we;
        cmd_idx   <= i_req_we ? wr_first_idx : '0;
        wbeat     <= '0;
        cmd_acc   <= 1'b0;
        beats_acc <= 1'b0;
        rd_cnt    <= '0;
      end

      if (state == WR) begin
        if (wr_step) begin
          cmd_idx   <= wr_next_idx;
          wbeat     <= '0;
          cmd_acc   <= 1'b0;
          beats_acc <= 1'b0;
        end else begin
          if (cmd_fire) cmd_acc <= 1'b1;
          if (beat_fire) begin
            if (last_beat) beats_acc <= 1'b1;
            else           wbeat     <= wbeat + WBW'(1);
          end
        end
      end

      if ((state == RD_CMD) && cmd_fire) cmd_idx <= cmd_idx + CW'(1);

      if (rd_take) begin
        rd_cnt <= rd_cnt_nxt;
        for (int j = 0; j < NBEATS; j++) begin
          if (rd_cnt == RCW'(j)) rsp_data_q[j*BEAT_W +: BEAT_W] <= i_app_rd_data;
        end
      end
    end
  end

endmodule
